// File: rtl/jrb8_pkg.sv
// Shared constants for the 7-segment display arbiter: FSM encoding,
// dwell counter width and the dwell_sel scaling shift.
package jrb8_pkg;

  localparam int unsigned CNT_W       = 24;
  localparam int unsigned DWELL_SHIFT = 10;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned SEG_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_display_arbiter_seg7.sv
// Hex digit to 7-segment decoder, active-high segments {g,f,e,d,c,b,a}.
// Ports:
//   i_digit  - 4-bit value 0..F
//   o_seg_c  - combinational segment pattern
module seg_display_arbiter_seg7
  import jrb8_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [SEG_W-1:0]   o_seg_c
);

  always_comb begin
    o_seg_c = '0;
    case (i_digit)
      4'h0: o_seg_c = 7'h3F;
      4'h1: o_seg_c = 7'h06;
      4'h2: o_seg_c = 7'h5B;
      4'h3: o_seg_c = 7'h4F;
      4'h4: o_seg_c = 7'h66;
      4'h5: o_seg_c = 7'h6D;
      4'h6: o_seg_c = 7'h7D;
      4'h7: o_seg_c = 7'h07;
      4'h8: o_seg_c = 7'h7F;
      4'h9: o_seg_c = 7'h6F;
      4'hA: o_seg_c = 7'h77;
      4'hB: o_seg_c = 7'h7C;
      4'hC: o_seg_c = 7'h39;
      4'hD: o_seg_c = 7'h5E;
      4'hE: o_seg_c = 7'h79;
      4'hF: o_seg_c = 7'h71;
      default: o_seg_c = '0;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment digit among N_REQ requesters.
// An owner is shown for a programmable dwell, followed by a one-cycle blank gap.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   req              - level-held display requests
//   value            - 4-bit digit per requester, requester i at [4i+3:4i]
//   dwell_sel        - 0: DWELL_DEFAULT, else dwell_sel << 10
//   grant            - one-hot current owner, zero when none
//   done             - one-cycle one-hot pulse on full-dwell completion
//   segments         - decoded pattern of the latched digit while showing
//   busy             - high while a requester owns the display
module seg_display_arbiter
  import jrb8_pkg::*;
#(
  parameter logic [23:0] DWELL_DEFAULT = 24'd10_000_000,
  parameter int unsigned N_REQ         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [DIGIT_W*N_REQ-1:0]   value,
  input  logic [7:0]                 dwell_sel,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic [SEG_W-1:0]           segments,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DIGIT_W-1:0]   r_digit_q;
  logic [PTR_W-1:0]     r_ptr;

  logic [CNT_W-1:0]     w_compare;
  logic [PTR_W-1:0]     w_idx;
  logic [PTR_W-1:0]     w_win;
  logic                 w_win_valid;
  logic [DIGIT_W-1:0]   w_win_digit;
  logic [SEG_W-1:0]     w_seg;

  // Live hold compare; dwell_sel changes take effect in the same cycle.
  assign w_compare = (dwell_sel == 8'd0) ? DWELL_DEFAULT
                                         : (CNT_W'(dwell_sel) << DWELL_SHIFT);

  // Round-robin pick: search ptr+1 .. ptr+N_REQ; walking the search order
  // backwards lets the earliest asserted index overwrite the later ones.
  always_comb begin
    w_win       = r_ptr;
    w_win_valid = 1'b0;
    w_idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % int'(N_REQ));
      if (req[w_idx]) begin
        w_win       = w_idx;
        w_win_valid = 1'b1;
      end
    end
  end

  assign w_win_digit = value[DIGIT_W*w_win +: DIGIT_W];

  seg_display_arbiter_seg7 u_seg7 (
    .i_digit (r_digit_q),
    .o_seg_c (w_seg)
  );

  // Blank whenever nobody owns the display (IDLE and GAP).
  assign segments = busy ? w_seg : '0;

  // Arbitration / dwell FSM; r_ptr doubles as the current owner index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_digit_q <= '0;
      r_ptr     <= PTR_W'(N_REQ - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state   <= ST_SHOW;
            r_cnt     <= '0;
            r_ptr     <= w_win;
            r_digit_q <= w_win_digit;
            grant     <= N_REQ'(1) << w_win;
            busy      <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (!req[r_ptr]) begin
            // Owner withdrew: abort, no completion pulse.
            r_state <= ST_GAP;
            grant   <= '0;
            busy    <= 1'b0;
          end else if (r_cnt == w_compare) begin
            r_state <= ST_GAP;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= N_REQ'(1) << r_ptr;
          end else begin
            // Wraps through all-ones if compare was lowered below cnt.
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          grant   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

  localparam logic [23:0] DWELL = 24'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] value;
  logic [7:0]  dwell_sel;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [6:0]  segments;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(.DWELL_DEFAULT(DWELL), .N_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .value     (value),
    .dwell_sel (dwell_sel),
    .grant     (grant),
    .done      (done),
    .segments  (segments),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Behavioural model: who owns the display, how long they've held it,
  // whether a blank gap is pending, and the last winner for round-robin.
  int         m_own   = -1;
  int         m_held  = 0;
  int         m_last  = 3;
  int         m_digit = 0;
  bit         m_gap   = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] e_grant = '0;
  logic [3:0] e_done  = '0;
  logic [6:0] e_seg   = '0;
  logic       e_busy  = 1'b0;

  always @(posedge clk) begin
    int limit;
    limit  = (dwell_sel == 8'd0) ? int'(DWELL) : int'(dwell_sel) * 1024;
    e_done = '0;
    if (reset) begin
      m_own = -1; m_held = 0; m_last = 3; m_digit = 0; m_gap = 1'b0;
      m_valid = 1'b1;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_own = -1; m_gap = 1'b1;
      end else if (m_held == limit) begin
        e_done = 4'(1 << m_own);
        m_own  = -1; m_gap = 1'b1;
      end else begin
        m_held = (m_held + 1) % (1 << 24);
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        if (req[(m_last + k) % 4]) begin
          m_own = (m_last + k) % 4;
          break;
        end
      end
      m_last  = m_own;
      m_held  = 0;
      m_digit = int'(value[m_own*4 +: 4]);
    end
    e_grant = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    e_busy  = (m_own >= 0);
    e_seg   = (m_own >= 0) ? seg_of(m_digit) : 7'b0;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant", 32'(grant), 32'(e_grant));
      chk("done", 32'(done), 32'(e_done));
      chk("segments", 32'(segments), 32'(e_seg));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("done_onehot0", 32'($onehot0(done)), 32'd1);
    end
  end

  task automatic do_reset();
    reset = 1'b1; req = '0; dwell_sel = '0; value = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_seg", 32'(segments), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  // Wait (bounded) for any grant; ok=0 on timeout.
  task automatic wait_grant(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (grant != 4'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Count negedges with grant held, starting on a granted cycle.
  task automatic count_held(input int bound, output int n);
    n = 0;
    while (grant != 4'b0 && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit         ok;
    int         n;
    logic [3:0] seq [3];
    int         gaps [3];
    int         ng;
    int         zrun;
    logic [3:0] prev;
    int         bi;

    reset = 1'b1; req = '0; value = '0; dwell_sel = '0;
    @(negedge clk);

    // Single requester, full dwell, gap, re-grant.
    do_reset();
    value = 16'h0007; req = 4'b0001; reset = 1'b0;
    @(negedge clk);
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_seg", 32'(segments), 32'h07);
    repeat (5) @(negedge clk);
    chk("s1_grant_last", 32'(grant), 32'h1);
    @(negedge clk);
    chk("s1_gap_grant", 32'(grant), 32'h0);
    chk("s1_done", 32'(done), 32'h1);
    chk("s1_gap_seg", 32'(segments), 32'h0);
    @(negedge clk);
    chk("s1_idle_done", 32'(done), 32'h0);
    chk("s1_idle_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("s1_regrant", 32'(grant), 32'h1);

    // All requesting: rotation order and two blank cycles between grants.
    do_reset();
    req = 4'b1111; reset = 1'b0;
    ng = 0; zrun = 0; prev = 4'b0;
    for (int i = 0; i < 60 && ng < 3; i++) begin
      @(negedge clk);
      if (grant != 4'b0 && prev == 4'b0) begin
        seq[ng] = grant; gaps[ng] = zrun; ng++;
      end
      zrun = (grant == 4'b0) ? zrun + 1 : 0;
      prev = grant;
    end
    chk("rr_count", 32'(ng), 32'd3);
    if (ng == 3) begin
      chk("rr_first", 32'(seq[0]), 32'h1);
      chk("rr_second", 32'(seq[1]), 32'h2);
      chk("rr_third", 32'(seq[2]), 32'h4);
      chk("rr_gap1", 32'(gaps[1]), 32'd2);
      chk("rr_gap2", 32'(gaps[2]), 32'd2);
    end

    // Abort on the third show cycle; digit B exercises hex decode.
    do_reset();
    value = 16'h00B0; req = 4'b0010; reset = 1'b0;
    @(negedge clk);
    chk("ab_grant", 32'(grant), 32'h2);
    chk("ab_seg", 32'(segments), 32'h7C);
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("ab_grant_clr", 32'(grant), 32'h0);
    chk("ab_no_done", 32'(done), 32'h0);
    chk("ab_seg_blank", 32'(segments), 32'h0);
    @(negedge clk);
    chk("ab_no_done2", 32'(done), 32'h0);

    // Long dwell from dwell_sel, then shorten mid-show.
    do_reset();
    value = 16'h0003; req = 4'b0001; dwell_sel = 8'd1; reset = 1'b0;
    wait_grant(10, ok);
    chk("dw_granted", 32'(ok), 32'd1);
    count_held(2000, n);
    chk("dw_1025", 32'(n), 32'd1025);
    chk("dw_done", 32'(done), 32'h1);
    wait_grant(10, ok);
    chk("dw_regrant", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    dwell_sel = 8'd0;
    count_held(2000, n);
    chk("dw_switch_len", 32'(n + 3), 32'd6);
    chk("dw_switch_done", 32'(done), 32'h1);

    // Reset while showing, then index 3 granted right after release.
    do_reset();
    value = 16'h1234; req = 4'b0001; reset = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1; req = 4'b1000;
    @(negedge clk);
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_seg", 32'(segments), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_grant3", 32'(grant), 32'h8);
    chk("mr_seg3", 32'(segments), 32'h06);

    // Randomized traffic checked cycle-by-cycle by the model.
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      value = 16'($urandom);
      if ($urandom_range(3) == 0) begin
        bi = int'($urandom_range(3));
        req[bi] = ~req[bi];
      end
      if ($urandom_range(299) == 0) dwell_sel = 8'd1;
      else if (dwell_sel != 8'd0 && $urandom_range(7) == 0) dwell_sel = 8'd0;
      reset = ($urandom_range(199) == 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
